sinfonia_nucleo_param: RTL

//   Parametrised sequence-game core for the next Sinfonia board: N-note Simon-style engine with internal sequence RAM.

---
 rtl/sinfonia_nucleo_param.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sinfonia_nucleo_param.sv
// sinfonia_nucleo_param
//   Simon-style sequence game core with internal sequence RAM. It plays rounds
//   of growing length on the leds, then times, registers and checks the player
//   presses. It keeps a saturating score. In training mode an error costs a
//   penalty and the round is replayed; otherwise the error ends the game.
//
// Optional feature: define SINFONIA_LFSR_EN to fill the sequence RAM from a
//   free-running 16-bit LFSR at every game start (state GERA). When it is
//   defined, the external write port is ignored.
//
// Ports
//   clock, reset      system clock, asynchronous active-low reset
//   jogar             start request (the rising edge is detected here)
//   nivel             0: game ends after PROF/2 rounds, 1: after PROF rounds
//   treinamento       training mode, latched at game start
//   botoes            synchronised buttons (level)
//   mem_we/addr/data  sequence RAM write port, accepted only while idle
//   leds              note being shown, or echo of the registered press
//   nota_valida       high while leds shows a sequence note
//   pontos, rodada    score and current round length
//   pronto/acertou/errou  game over / won / lost
//   db_estado         state code for debug
module sinfonia_nucleo_param #(
    parameter int N_NOTAS    = 7,
    parameter int PROF       = 16,
    parameter int W_PONTOS   = 8,
    parameter int PONTOS_INI = 100,
    parameter int BONUS      = 10,
    parameter int PENALIDADE = 5,
    parameter int T_NOTA     = 25_000_000,
    parameter int T_PAUSA    = 12_500_000,
    parameter int T_JOGADA   = 250_000_000,
    localparam int NW        = $clog2(N_NOTAS),
    localparam int AW        = $clog2(PROF)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                nivel,
    input  logic                treinamento,
    input  logic [N_NOTAS-1:0]  botoes,
    input  logic                mem_we,
    input  logic [AW-1:0]       mem_addr,
    input  logic [NW-1:0]       mem_data,
    output logic [N_NOTAS-1:0]  leds,
    output logic                nota_valida,
    output logic [W_PONTOS-1:0] pontos,
    output logic [AW:0]         rodada,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic [3:0]          db_estado
);
    localparam logic [3:0] S_INICIAL    = 4'h0;
    localparam logic [3:0] S_PREPARA    = 4'h1;
    localparam logic [3:0] S_MOSTRA     = 4'h2;
    localparam logic [3:0] S_PAUSA      = 4'h3;
    localparam logic [3:0] S_ESPERA     = 4'h4;
    localparam logic [3:0] S_REGISTRA   = 4'h5;
    localparam logic [3:0] S_COMPARA    = 4'h6;
    localparam logic [3:0] S_LIBERA     = 4'h7;
    localparam logic [3:0] S_PROX       = 4'h8;
    localparam logic [3:0] S_PENALIZA   = 4'h9;
    localparam logic [3:0] S_FIM_ACERTO = 4'hA;
    localparam logic [3:0] S_FIM_ERRO   = 4'hB;
    localparam logic [3:0] S_GERA       = 4'hC;

    localparam logic [AW:0] LIM_ALTO  = (AW+1)'(PROF);
    localparam logic [AW:0] LIM_BAIXO = (AW+1)'(PROF / 2);

    logic [3:0]          estado_q, estado_d;
    logic [31:0]         timer_q, timer_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW:0]         rodada_q, rodada_d;
    logic [W_PONTOS-1:0] pontos_q, pontos_d;
    logic                treino_q, treino_d;
    logic [N_NOTAS-1:0]  jogada_q, jogada_d;
    logic                jogar_q, jogar_d;

    // Sequence RAM: never reset, its contents are undefined until written.
    logic [NW-1:0] mem [PROF];
    logic          mem_wr;
    logic [AW-1:0] mem_wr_addr;
    logic [NW-1:0] mem_wr_data;

    logic                jogar_borda, ocioso, ultima, erro;
    logic [AW:0]         limite;
    logic [N_NOTAS-1:0]  nota_oh;
    logic [W_PONTOS:0]   soma;
    logic [W_PONTOS-1:0] pontos_mais, pontos_menos;

    assign jogar_borda = jogar & ~jogar_q;
    assign ocioso      = (estado_q == S_INICIAL) || (estado_q == S_FIM_ACERTO) ||
                         (estado_q == S_FIM_ERRO);
    assign limite      = nivel ? LIM_ALTO : LIM_BAIXO;
    assign nota_oh     = N_NOTAS'(1) << mem[addr_q];
    // addr_q points at the last note of the current round
    assign ultima      = ({1'b0, addr_q} + (AW+1)'(1)) == rodada_q;

    // Saturating score arithmetic: one extra carry bit for the add; the
    // subtraction clamps at zero before it can wrap.
    assign soma         = {1'b0, pontos_q} + (W_PONTOS+1)'(BONUS);
    assign pontos_mais  = soma[W_PONTOS] ? '1 : soma[W_PONTOS-1:0];
    assign pontos_menos = (32'(pontos_q) < PENALIDADE) ? '0 :
                          pontos_q - W_PONTOS'(PENALIDADE);

`ifdef SINFONIA_LFSR_EN
    logic [15:0]   lfsr_q, lfsr_d;
    logic [NW-1:0] nota_gerada;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    always_comb begin
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        nota_gerada = NW'(32'(lfsr_q[NW-1:0]) % N_NOTAS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end

    always_comb begin
        mem_wr      = (estado_q == S_GERA);
        mem_wr_addr = addr_q;
        mem_wr_data = nota_gerada;
    end
`else
    always_comb begin
        mem_wr      = mem_we && ocioso && (32'(mem_addr) < PROF);
        mem_wr_addr = mem_addr;
        mem_wr_data = (32'(mem_data) < N_NOTAS) ? mem_data : '0;
    end
`endif

    always_ff @(posedge clock) begin
        if (mem_wr) mem[mem_wr_addr] <= mem_wr_data;
    end

    always_comb begin
        estado_d = estado_q;
        addr_d   = addr_q;
        rodada_d = rodada_q;
        pontos_d = pontos_q;
        treino_d = treino_q;
        jogada_d = jogada_q;
        jogar_d  = jogar;
        erro     = 1'b0;

        case (estado_q)
            S_INICIAL, S_FIM_ACERTO, S_FIM_ERRO: begin
                if (jogar_borda) begin
                    pontos_d = W_PONTOS'(PONTOS_INI);
                    rodada_d = (AW+1)'(1);
                    treino_d = treinamento;
                    addr_d   = '0;
`ifdef SINFONIA_LFSR_EN
                    estado_d = S_GERA;
`else
                    estado_d = S_PREPARA;
`endif
                end
            end
`ifdef SINFONIA_LFSR_EN
            S_GERA: begin
                if (addr_q == AW'(PROF - 1)) begin
                    addr_d   = '0;
                    estado_d = S_PREPARA;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
`endif
            S_PREPARA: begin
                addr_d   = '0;
                estado_d = S_MOSTRA;
            end
            S_MOSTRA: begin
                if (timer_q == 32'(T_NOTA - 1)) estado_d = S_PAUSA;
            end
            S_PAUSA: begin
                if (timer_q == 32'(T_PAUSA - 1)) begin
                    if (ultima) begin
                        addr_d   = '0;
                        estado_d = S_ESPERA;
                    end else begin
                        addr_d   = addr_q + AW'(1);
                        estado_d = S_MOSTRA;
                    end
                end
            end
            S_ESPERA: begin
                // A press wins over a timeout that lands on the same cycle.
                if (botoes != '0) begin
                    jogada_d = botoes;
                    estado_d = S_REGISTRA;
                end else if (timer_q == 32'(T_JOGADA - 1)) begin
                    erro = 1'b1;
                end
            end
            S_REGISTRA: estado_d = S_COMPARA;
            S_COMPARA: begin
                if (jogada_q == nota_oh) estado_d = S_LIBERA;
                else                     erro     = 1'b1;
            end
            S_LIBERA: begin
                // Holding the button here keeps it from being counted twice.
                if (botoes == '0) begin
                    if (ultima) begin
                        estado_d = S_PROX;
                    end else begin
                        addr_d   = addr_q + AW'(1);
                        estado_d = S_ESPERA;
                    end
                end
            end
            S_PROX: begin
                pontos_d = pontos_mais;
                if (rodada_q == limite) begin
                    estado_d = S_FIM_ACERTO;
                end else begin
                    rodada_d = rodada_q + (AW+1)'(1);
                    estado_d = S_PREPARA;
                end
            end
            S_PENALIZA: begin
                if (botoes == '0) estado_d = S_PREPARA;
            end
            default: estado_d = S_INICIAL;
        endcase

        // The penalty is applied once, on the way into PENALIZA.
        if (erro) begin
            if (treino_q) begin
                pontos_d = pontos_menos;
                estado_d = S_PENALIZA;
            end else begin
                estado_d = S_FIM_ERRO;
            end
        end

        // Every state entry starts its own timing window.
        timer_d = (estado_d != estado_q) ? '0 : timer_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= S_INICIAL;
            timer_q  <= '0;
            addr_q   <= '0;
            rodada_q <= '0;
            pontos_q <= '0;
            treino_q <= 1'b0;
            jogada_q <= '0;
            jogar_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            rodada_q <= rodada_d;
            pontos_q <= pontos_d;
            treino_q <= treino_d;
            jogada_q <= jogada_d;
            jogar_q  <= jogar_d;
        end
    end

    always_comb begin
        leds = '0;
        if (estado_q == S_MOSTRA) leds = nota_oh;
        else if ((estado_q == S_COMPARA) || (estado_q == S_LIBERA)) leds = jogada_q;
    end

    assign nota_valida = (estado_q == S_MOSTRA);
    assign pontos      = pontos_q;
    assign rodada      = rodada_q;
    assign pronto      = (estado_q == S_FIM_ACERTO) || (estado_q == S_FIM_ERRO);
    assign acertou     = (estado_q == S_FIM_ACERTO);
    assign errou       = (estado_q == S_FIM_ERRO);
    assign db_estado   = estado_q;

endmodule
